// File: rtl/pipe_mem_arbiter_pkg.sv
// rtl/pipe_mem_arbiter_pkg.sv - shared types and helpers for the IF/MEM memory arbiter
package pipe_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// rtl/pipe_mem_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface pipe_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              flush_i;
  logic              if_done_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_done_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_if_o;
  logic              stall_mem_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output if_done_o, if_rdata_o, dm_done_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_mem_o
  );

  // Pipeline stages and memory model side
  modport master (
    output if_req_i, if_addr_i, flush_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  if_done_o, if_rdata_o, dm_done_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_mem_o
  );
endinterface

// File: rtl/pipe_mem_arbiter_starve_cnt.sv
// rtl/pipe_mem_arbiter_starve_cnt.sv - saturating count of MEM wins over a waiting fetch
module pipe_starve_cnt
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  localparam int unsigned W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);
endmodule

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - single-port memory shared by fetch and load/store, MEM first
// with a forced fetch grant after STARVE_MAX consecutive MEM wins over a waiting fetch.
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk_i,
  input logic                rst_n,
  pipe_mem_arbiter_if.slave  bus
);
  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              drop_q, drop_d;
  logic              starve_inc, starve_clr, starve_at_max;
  logic              grant_if, grant_dm;

  pipe_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  assign grant_if = bus.if_req_i & (~bus.dm_req_i | starve_at_max);
  assign grant_dm = bus.dm_req_i & ~grant_if;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    drop_d      = drop_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        if (grant_if) begin
          state_d     = ST_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
          drop_d      = bus.flush_i;
          starve_clr  = 1'b1;
        end else if (grant_dm) begin
          state_d     = ST_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          starve_inc  = bus.if_req_i;
        end
      end
      ST_BUSY_IF: begin
        // A flush arriving on the completing cycle still discards the fetch.
        drop_d = drop_q | bus.flush_i;
        if (bus.mem_ready_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!(drop_q | bus.flush_i)) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      ST_BUSY_DM: begin
        if (bus.mem_ready_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          dm_done_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.dm_done_o   = dm_done_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.stall_if_o  = bus.if_req_i & ~if_done_q;
  assign bus.stall_mem_o = bus.dm_req_i & ~dm_done_q;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - directed table, corner sequences and randomized run vs a model
module tb_pipe_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pipe_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: which requester owns the memory, whether its fetch was flushed,
  // and how many times MEM has beaten a waiting fetch.
  int          m_busy = 0;
  bit          m_drop = 0;
  int          m_starve = 0;
  logic [31:0] m_addr = 0;
  bit          m_we = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] exp_if_rdata = 0;
  logic [31:0] exp_dm_rdata = 0;
  int          grant_log[$];
  int          if_done_cnt = 0;
  int          dm_done_cnt = 0;
  logic [31:0] obs_addr = 0;
  logic [31:0] obs_wdata = 0;
  bit          obs_we = 0;

  bit          mem_auto = 0, mem_rand = 0, mem_noise = 0, mem_fixed = 0;
  int          mem_lat = 0, mem_wait = 0;
  logic [31:0] mem_fixed_val = 0;
  bit          if_auto = 0, dm_auto = 0;
  int          new_pct = 0, flush_pct = 0;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    int          exp_ticks;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tab[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_starve = 0;
    exp_if_rdata = 0; exp_dm_rdata = 0;
  endtask

  task automatic tick();
    logic        pir, pf, pdr, pdw, pr, pmr;
    logic [31:0] pia, pda, pdwd, prd;
    bit          e_req;
    int          e_ifd, e_dmd;
    pir = bus.if_req_i; pia = bus.if_addr_i; pf = bus.flush_i;
    pdr = bus.dm_req_i; pdw = bus.dm_we_i; pda = bus.dm_addr_i; pdwd = bus.dm_wdata_i;
    pr = bus.mem_ready_i; prd = bus.mem_rdata_i; pmr = bus.mem_req_o;
    @(posedge clk);
    #1;
    e_ifd = 0; e_dmd = 0; e_req = 0;
    if (m_busy != 0) begin
      if (m_busy == 1 && pf) m_drop = 1;
      if (pr) begin
        if (m_busy == 1) begin
          if (!m_drop) begin e_ifd = 1; exp_if_rdata = prd; end
        end else begin
          e_dmd = 1;
          if (!m_we) exp_dm_rdata = prd;
        end
        m_busy = 0; m_drop = 0;
      end else begin
        e_req = 1;
      end
    end else if (pir || pdr) begin
      if (pir && (!pdr || m_starve == SMAX)) begin
        m_busy = 1; m_starve = 0; m_addr = pia; m_we = 0; m_wdata = 0; m_drop = pf;
      end else begin
        m_busy = 2;
        if (pir && m_starve < SMAX) m_starve++;
        m_addr = pda; m_we = pdw; m_wdata = pdwd;
      end
      grant_log.push_back(m_busy);
      e_req = 1;
    end
    chk("mem_req", bus.mem_req_o, e_req);
    if (e_req) begin
      chk("mem_addr", bus.mem_addr_o, m_addr);
      chk("mem_we", bus.mem_we_o, m_we);
      if (m_we) chk("mem_wdata", bus.mem_wdata_o, m_wdata);
    end
    chk("if_done", bus.if_done_o, e_ifd);
    if (e_ifd != 0) chk("if_rdata", bus.if_rdata_o, exp_if_rdata);
    chk("dm_done", bus.dm_done_o, e_dmd);
    chk("dm_rdata", bus.dm_rdata_o, exp_dm_rdata);
    chk("stall_if", bus.stall_if_o, bus.if_req_i & (e_ifd == 0));
    chk("stall_mem", bus.stall_mem_o, bus.dm_req_i & (e_dmd == 0));
    if (bus.if_done_o) if_done_cnt++;
    if (bus.dm_done_o) dm_done_cnt++;
    if (bus.mem_req_o && !pmr) begin
      obs_addr = bus.mem_addr_o; obs_we = bus.mem_we_o; obs_wdata = bus.mem_wdata_o;
    end
    if (mem_auto) begin
      bus.mem_ready_i = 1'b0;
      if (bus.mem_req_o) begin
        if (mem_wait >= mem_lat) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_rdata_i = mem_fixed ? mem_fixed_val : 32'($urandom);
          mem_wait = 0;
        end else begin
          mem_wait++;
        end
      end else begin
        mem_wait = 0;
        if (mem_rand) mem_lat = $urandom_range(0, 3);
        if (mem_noise && $urandom_range(0, 3) == 0) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_rdata_i = $urandom;
        end
      end
    end
    if (if_auto) begin
      if (bus.if_done_o) begin
        bus.if_req_i = ($urandom_range(0, 99) < new_pct);
        bus.if_addr_i = rnd_addr();
      end else if (!bus.if_req_i && $urandom_range(0, 99) < new_pct) begin
        bus.if_req_i = 1'b1;
        bus.if_addr_i = rnd_addr();
      end
      bus.flush_i = bus.if_req_i && ($urandom_range(0, 99) < flush_pct);
      if (bus.flush_i) bus.if_addr_i = rnd_addr();
    end
    if (dm_auto) begin
      if (bus.dm_done_o || (!bus.dm_req_i && $urandom_range(0, 99) < new_pct)) begin
        bus.dm_req_i = bus.dm_done_o ? ($urandom_range(0, 99) < new_pct) : 1'b1;
        bus.dm_we_i = 1'($urandom_range(0, 1));
        bus.dm_addr_i = rnd_addr();
        bus.dm_wdata_i = $urandom;
      end
    end
  endtask

  initial begin
    int n, c0;
    int exp_order[10];
    tab[0] = '{0, 0, 32'h40,        32'h0,        2, 32'h0000_0013, 4, 32'h0000_0013};
    tab[1] = '{1, 1, 32'h10,        32'hDEAD_BEEF, 0, 32'h1111_1111, 2, 32'h0};
    tab[2] = '{1, 0, 32'h24,        32'h0,        1, 32'hCAFE_0001, 3, 32'hCAFE_0001};
    tab[3] = '{1, 1, 32'h0,         32'h1234_5678, 3, 32'h0000_0022, 5, 32'hCAFE_0001};
    tab[4] = '{0, 0, 32'hFFFF_FFFC, 32'h0,        0, 32'h8000_0000, 2, 32'h8000_0000};
    tab[5] = '{1, 0, 32'h80,        32'h0,        2, 32'h0,         4, 32'h0};
    exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    bus.if_req_i = 0; bus.if_addr_i = 0; bus.flush_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = 0; bus.dm_wdata_i = 0;
    bus.mem_ready_i = 0; bus.mem_rdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_if_done", bus.if_done_o, 0);
    chk("rst_dm_done", bus.dm_done_o, 0);
    chk("rst_if_rdata", bus.if_rdata_o, 0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 0);
    rst_n = 1'b1;
    tick();

    // Single accesses from the vector table
    mem_auto = 1; mem_fixed = 1;
    foreach (tab[i]) begin
      mem_lat = tab[i].lat; mem_fixed_val = tab[i].rdata;
      if (tab[i].is_dm) begin
        bus.dm_req_i = 1; bus.dm_we_i = tab[i].we;
        bus.dm_addr_i = tab[i].addr; bus.dm_wdata_i = tab[i].wdata;
      end else begin
        bus.if_req_i = 1; bus.if_addr_i = tab[i].addr;
      end
      n = 0;
      do begin
        tick(); n++;
      end while (!(tab[i].is_dm ? bus.dm_done_o : bus.if_done_o) && n < 20);
      chk($sformatf("tab%0d_ticks", i), n, tab[i].exp_ticks);
      chk($sformatf("tab%0d_addr", i), obs_addr, tab[i].addr);
      chk($sformatf("tab%0d_we", i), obs_we, tab[i].we);
      if (tab[i].we) chk($sformatf("tab%0d_wdata", i), obs_wdata, tab[i].wdata);
      chk($sformatf("tab%0d_rdata", i),
          tab[i].is_dm ? bus.dm_rdata_o : bus.if_rdata_o, tab[i].exp_rdata);
      bus.if_req_i = 0; bus.dm_req_i = 0;
      tick();
      chk($sformatf("tab%0d_stall_if", i), bus.stall_if_o, 0);
    end

    // Ready held high in IDLE and through a busy fetch: exactly one done
    mem_auto = 0;
    bus.mem_ready_i = 1; bus.mem_rdata_i = 32'h77;
    repeat (3) tick();
    c0 = if_done_cnt;
    bus.if_req_i = 1; bus.if_addr_i = 32'h200;
    repeat (3) begin
      tick();
      if (bus.if_done_o) bus.if_req_i = 0;
    end
    bus.mem_ready_i = 0;
    repeat (2) tick();
    chk("ready_held_one_done", if_done_cnt - c0, 1);

    // Flush while the fetch is in flight; the redirected fetch is served
    mem_auto = 1; mem_fixed = 0; mem_lat = 3;
    c0 = if_done_cnt;
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    tick(); tick();
    bus.flush_i = 1; bus.if_addr_i = 32'h80;
    tick();
    bus.flush_i = 0;
    n = 0;
    while (!bus.if_done_o && n < 30) begin tick(); n++; end
    chk("flush_done_seen", bus.if_done_o, 1);
    chk("flush_one_done", if_done_cnt - c0, 1);
    chk("flush_new_addr", obs_addr, 32'h80);
    bus.if_req_i = 0;
    tick();

    // Asynchronous reset while a store is waiting on memory
    mem_fixed = 1; mem_fixed_val = 32'h5; mem_lat = 10;
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h44; bus.dm_wdata_i = 32'h99;
    tick(); tick();
    chk("arst_pre_req", bus.mem_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", bus.mem_req_o, 0);
    chk("arst_mem_we", bus.mem_we_o, 0);
    chk("arst_if_done", bus.if_done_o, 0);
    chk("arst_dm_done", bus.dm_done_o, 0);
    model_reset();
    bus.dm_req_i = 0;
    tick(); tick();
    rst_n = 1'b1;
    mem_lat = 1; mem_fixed_val = 32'hABCD;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h30;
    n = 0;
    while (!bus.dm_done_o && n < 20) begin tick(); n++; end
    chk("arst_fresh_done", bus.dm_done_o, 1);
    chk("arst_fresh_rdata", bus.dm_rdata_o, 32'hABCD);
    bus.dm_req_i = 0;
    tick();

    // Both requesters continuously pending: starvation override pattern
    mem_fixed = 0; mem_rand = 1; if_auto = 1; dm_auto = 1; new_pct = 100; flush_pct = 0;
    grant_log.delete();
    bus.if_req_i = 1; bus.if_addr_i = rnd_addr();
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = rnd_addr();
    n = 0;
    while (grant_log.size() < 10 && n < 300) begin tick(); n++; end
    chk("starve_grants", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("starve_order%0d", i), grant_log[i], exp_order[i]);

    // Randomized traffic, flushes and spurious ready in IDLE
    new_pct = 60; flush_pct = 5; mem_noise = 1;
    repeat (3000) tick();
    chk("rand_progress", (if_done_cnt > 20) && (dm_done_cnt > 20), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
